// File: rtl/serdes_rx_deframer.sv
// serdes_rx_deframer
//   Serial frame receiver. It hunts for SYNC_WORD on rx_bit, then collects a 32-bit payload
//   (MSB first) and, when PARITY_EN is set, one even-parity bit. Good frames are pushed into a
//   2-entry FIFO that drives an AXI-Stream master port.
// Ports
//   rx_clk          : single clock, rising edge
//   rx_reset        : asynchronous active-high reset
//   rx_bit          : serial data, one bit per rx_clk
//   m_axis_tdata    : head-of-FIFO payload word
//   m_axis_valid    : FIFO not empty
//   m_axis_ready    : consumer ready
//   locked          : high while a frame body (payload/parity) is being received
//   frame_cnt       : frames pushed into the FIFO (saturating)
//   parity_err_cnt  : frames dropped for bad parity (saturating)
//   overflow_cnt    : good frames dropped because the FIFO was full (saturating)
module serdes_rx_deframer #(
   parameter logic [7:0] SYNC_WORD = 8'hD5,
   parameter bit         PARITY_EN = 1'b1
) (
   input  logic        rx_clk,
   input  logic        rx_reset,
   input  logic        rx_bit,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_valid,
   input  logic        m_axis_ready,
   output logic        locked,
   output logic [15:0] frame_cnt,
   output logic [15:0] parity_err_cnt,
   output logic [15:0] overflow_cnt
);

   typedef enum logic [1:0] {StHunt, StPayload, StParity} state_e;

   state_e      state_q, state_d;
   logic [7:0]  hist_q, hist_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic        frame_done, frame_good;
   logic [31:0] frame_word;

   // Frame FSM
   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      frame_done = 1'b0;
      frame_good = 1'b0;
      frame_word = shift_q;
      unique case (state_q)
         StHunt: begin
            // Match includes the bit being sampled on this edge.
            hist_d = {hist_q[6:0], rx_bit};
            if (hist_d == SYNC_WORD) begin
               state_d   = StPayload;
               bit_cnt_d = 5'd0;
            end
         end
         StPayload: begin
            shift_d   = {shift_q[30:0], rx_bit};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
               if (PARITY_EN) begin
                  state_d = StParity;
               end else begin
                  frame_done = 1'b1;
                  frame_good = 1'b1;
                  frame_word = shift_d;
                  state_d    = StHunt;
                  hist_d     = 8'h00;
               end
            end
         end
         StParity: begin
            frame_done = 1'b1;
            frame_good = ~((^shift_q) ^ rx_bit);
            state_d    = StHunt;
            // Clear history so stale payload bits can never complete a sync match.
            hist_d     = 8'h00;
         end
         default: begin
            state_d = StHunt;
            hist_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         state_q   <= StHunt;
         hist_q    <= 8'h00;
         bit_cnt_q <= 5'd0;
         shift_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Output FIFO: 2 entries, explicit occupancy count
   logic [31:0] mem_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  count_q, count_d;
   logic        pop, push, drop, perr;

   assign pop  = (count_q != 2'd0) && m_axis_ready;
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push = frame_done && frame_good && ((count_q != 2'd2) || pop);
   assign drop = frame_done && frame_good && !push;
   assign perr = frame_done && !frame_good;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         mem_q[0] <= 32'h0;
         mem_q[1] <= 32'h0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= frame_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Saturating statistics counters
   logic [15:0] frame_cnt_q, perr_cnt_q, ovf_cnt_q;

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         frame_cnt_q <= 16'h0;
         perr_cnt_q  <= 16'h0;
         ovf_cnt_q   <= 16'h0;
      end else begin
         if (push && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (perr && (perr_cnt_q != 16'hFFFF)) begin
            perr_cnt_q <= perr_cnt_q + 16'd1;
         end
         if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
         end
      end
   end

   assign m_axis_valid   = (count_q != 2'd0);
   assign m_axis_tdata   = mem_q[rd_ptr_q];
   assign locked         = (state_q != StHunt);
   assign frame_cnt      = frame_cnt_q;
   assign parity_err_cnt = perr_cnt_q;
   assign overflow_cnt   = ovf_cnt_q;

endmodule

// File: doc/serdes_rx_deframer.md
SERDES_RX_DEFRAMER -- requirements
Module: serdes_rx_deframer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hD5, 8-bit frame header matched MSB-first on the serial line.
REQ-002 Parameter PARITY_EN, default 1, enables the even-parity bit after the payload; when 0, no parity bit is received or checked.
REQ-003 Port rx_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rx_reset, input, 1, asynchronous active-high reset.
REQ-005 Port rx_bit, input, 1, phase-selected serial data, one bit per rx_clk.
REQ-006 Port m_axis_tdata, output, 32, received payload word.
REQ-007 Port m_axis_valid, output, 1, AXI-Stream valid.
REQ-008 Port m_axis_ready, input, 1, AXI-Stream ready from the consumer.
REQ-009 Port locked, output, 1, high while a frame body (payload or parity) is being received.
REQ-010 Port frame_cnt, output, 16, count of frames accepted into the buffer, saturating at 16'hFFFF.
REQ-011 Port parity_err_cnt, output, 16, count of frames dropped for bad parity, saturating.
REQ-012 Port overflow_cnt, output, 16, count of good frames dropped because the buffer was full, saturating.

Function
REQ-013 Frame format SHALL be SYNC_WORD (8 bits), then payload (32 bits), then parity (1 bit, only if PARITY_EN), all MSB first, with no gap between fields.
REQ-014 The FSM SHALL have states HUNT, PAYLOAD, PARITY.
REQ-015 HUNT: shift rx_bit into an 8-bit history register each cycle; when the register including the current bit equals SYNC_WORD, go to PAYLOAD on the next edge with the bit counter cleared.
REQ-016 PAYLOAD: shift 32 bits MSB first; after the 32nd bit go to PARITY if PARITY_EN, else complete the frame and go to HUNT.
REQ-017 PARITY: sample one bit; XOR of the 32 payload bits and the parity bit equal to 0 means good; either way go to HUNT.
REQ-018 On entry to HUNT, the history register SHALL be cleared to 8'h00, so sync is never matched inside the previous frame's bits.
REQ-019 locked SHALL be 1 in PAYLOAD and PARITY, 0 in HUNT.
REQ-020 Output buffer SHALL be a 2-entry FIFO; m_axis_valid = not empty; m_axis_tdata = head entry, held stable while valid and not ready.
REQ-021 A pop SHALL occur when m_axis_valid and m_axis_ready are both high at a clock edge.
REQ-022 A good frame SHALL be pushed on the edge that completes it and be visible on m_axis_valid the next cycle, i.e. 1 cycle after the last frame bit.
REQ-023 A push and a pop on the same edge with the FIFO full SHALL both succeed; the new frame is not dropped.
REQ-024 A good frame arriving while the FIFO is full and no pop occurs SHALL be dropped, and overflow_cnt increments.
REQ-025 A bad-parity frame SHALL NOT be pushed, and parity_err_cnt increments.
REQ-026 frame_cnt SHALL increment on each push.
REQ-027 All counters SHALL saturate and never wrap.
REQ-028 FIFO pointers SHALL wrap modulo 2 using an explicit occupancy count (0..2).

Reset
REQ-029 While rx_reset is high, the block SHALL be in HUNT with history 8'h00, bit counter 0, FIFO empty, m_axis_valid 0, m_axis_tdata 32'h0, locked 0, and all counters 0.
REQ-030 Reset asserted mid-frame or with the FIFO non-empty SHALL discard all partial and buffered data with no counter update.
REQ-031 Reset SHALL take effect asynchronously; the first sync search starts on the first rx_clk edge after deassertion.

Verification
REQ-032 Idle 0s, then frame D5 + DEADBEEF + parity 0, with ready=1 -> one beat of tdata=32'hDEADBEEF, 1 cycle after the parity bit; frame_cnt=1.
REQ-033 Same frame with parity bit 1 -> no valid; parity_err_cnt=1; the next correct frame is still received.
REQ-034 ready=0, three back-to-back good frames 0x1, 0x2, 0x3 -> FIFO holds 0x1, 0x2; overflow_cnt=1; after raising ready, beats 0x1 then 0x2 appear.
REQ-035 Payload containing 0xD5 bytes (32'hD5D5D5D5) -> received intact, with no false resync mid-frame.
REQ-036 FIFO full, with ready asserted on the same edge the 3rd frame completes -> no drop; output order is preserved.
REQ-037 rx_reset pulsed during PAYLOAD with a buffered word present -> valid drops to 0, locked goes to 0, counters read 0, and the next full frame is received correctly.
